// File: rtl/gate_sweep_pkg.sv
// Shared types and the reference-gate function for the exhaustive gate sweep checker.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'd0,
    MODE_OR   = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_NAND = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Expected gate output for the low n bits of vec; bits at or above n are masked off.
  function automatic logic gate_ref(input mode_e m, input logic [7:0] vec, input int n);
    logic [7:0] mask_v;
    logic       res_v;
    mask_v = 8'hFF >> (8 - n);
    case (m)
      MODE_AND:  res_v = &(vec | ~mask_v);
      MODE_OR:   res_v = |(vec & mask_v);
      MODE_XOR:  res_v = ^(vec & mask_v);
      MODE_NAND: res_v = ~&(vec | ~mask_v);
      default:   res_v = 1'b0;
    endcase
    return res_v;
  endfunction

endpackage

// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus-and-check engine: walks every input vector of an N_IN-input gate,
// holds each for DWELL_CYCLES clocks and compares the gate output with a reference.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int N_IN         = 2,
  parameter int DWELL_CYCLES = 100,
  parameter int ERR_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [N_IN-1:0]   dut_in,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_fail_valid,
  output logic [N_IN-1:0]   first_fail_vec
);

  localparam int               DW_W       = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [N_IN:0]    VEC_LAST   = {1'b0, {N_IN{1'b1}}};
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

  state_e            state_r;
  mode_e             mode_r;
  logic [N_IN:0]     vec_r;
  logic [DW_W-1:0]   dwell_r;
  logic [N_IN-1:0]   dut_in_r;
  logic [N_IN-1:0]   ffvec_r;
  logic              busy_r;
  logic              done_r;
  logic              pass_r;
  logic              ffv_r;
  logic [ERR_W-1:0]  err_r;

  logic              sample_s;
  logic              mismatch_s;
  logic [7:0]        vec8_s;
  logic [N_IN:0]     vec_inc_s;
  logic [ERR_W-1:0]  err_next_s;

  // Compare strobe, reference check and saturating next error count.
  always_comb begin
    vec8_s             = 8'd0;
    vec8_s[N_IN-1:0]   = vec_r[N_IN-1:0];
    vec_inc_s          = vec_r + (N_IN+1)'(1);
    sample_s           = (state_r == RUN) && (dwell_r == DWELL_LAST);
    mismatch_s         = sample_s && (dut_out != gate_ref(mode_r, vec8_s, N_IN));
    if (mismatch_s && (err_r != ERR_MAX)) begin
      err_next_s = err_r + ERR_W'(1);
    end else begin
      err_next_s = err_r;
    end
  end

  // Sweep FSM, dwell/vector counters and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      mode_r   <= MODE_AND;
      vec_r    <= {(N_IN+1){1'b0}};
      dwell_r  <= {DW_W{1'b0}};
      dut_in_r <= {N_IN{1'b0}};
      ffvec_r  <= {N_IN{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
      ffv_r    <= 1'b0;
      err_r    <= {ERR_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r  <= RUN;
            mode_r   <= mode_e'(mode);
            vec_r    <= {(N_IN+1){1'b0}};
            dwell_r  <= {DW_W{1'b0}};
            dut_in_r <= {N_IN{1'b0}};
            ffvec_r  <= {N_IN{1'b0}};
            busy_r   <= 1'b1;
            pass_r   <= 1'b0;
            ffv_r    <= 1'b0;
            err_r    <= {ERR_W{1'b0}};
          end
        end
        RUN: begin
          if (sample_s) begin
            err_r   <= err_next_s;
            dwell_r <= {DW_W{1'b0}};
            if (mismatch_s && !ffv_r) begin
              ffv_r   <= 1'b1;
              ffvec_r <= vec_r[N_IN-1:0];
            end
            // The extra counter bit keeps the last-vector test from wrapping to zero.
            if (vec_r == VEC_LAST) begin
              state_r  <= DONE;
              done_r   <= 1'b1;
              pass_r   <= (err_next_s == {ERR_W{1'b0}});
              dut_in_r <= {N_IN{1'b0}};
            end else begin
              vec_r    <= vec_inc_s;
              dut_in_r <= vec_inc_s[N_IN-1:0];
            end
          end else begin
            dwell_r <= dwell_r + DW_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          dut_in_r <= {N_IN{1'b0}};
        end
      endcase
    end
  end

  assign dut_in           = dut_in_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign err_count        = err_r;
  assign first_fail_valid = ffv_r;
  assign first_fail_vec   = ffvec_r;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed scoreboard bench for gate_sweep_checker: a 2-input instance and a 3-input,
// 2-bit-error-counter instance share the clock and reset.
module tb_gate_sweep_checker;

  localparam int DW = 4;

  typedef struct {
    int   err;
    logic pass;
    logic ffv;
    int   ffvec;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_start, a_dut_out, a_busy, a_done, a_pass, a_ffv, a_tie0;
  logic [1:0] a_mode, a_dut_in, a_ffvec;
  logic [7:0] a_err;
  logic       b_start, b_dut_out, b_busy, b_done, b_pass, b_ffv;
  logic [1:0] b_mode, b_err;
  logic [2:0] b_dut_in, b_ffvec;

  assign a_dut_out = a_tie0 ? 1'b0 : &a_dut_in;
  assign b_dut_out = &b_dut_in;

  gate_sweep_checker #(.N_IN(2), .DWELL_CYCLES(DW), .ERR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .mode(a_mode), .dut_in(a_dut_in),
    .dut_out(a_dut_out), .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
    .first_fail_valid(a_ffv), .first_fail_vec(a_ffvec));

  gate_sweep_checker #(.N_IN(3), .DWELL_CYCLES(DW), .ERR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode), .dut_in(b_dut_in),
    .dut_out(b_dut_out), .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
    .first_fail_valid(b_ffv), .first_fail_vec(b_ffvec));

  logic       cur_b;
  logic [7:0] o_in, o_err, o_ffvec;
  logic       o_busy, o_done, o_pass, o_ffv;

  always_comb begin
    if (cur_b) begin
      o_in = {5'd0, b_dut_in}; o_err = {6'd0, b_err}; o_ffvec = {5'd0, b_ffvec};
      o_busy = b_busy; o_done = b_done; o_pass = b_pass; o_ffv = b_ffv;
    end else begin
      o_in = {6'd0, a_dut_in}; o_err = a_err; o_ffvec = {6'd0, a_ffvec};
      o_busy = a_busy; o_done = a_done; o_pass = a_pass; o_ffv = a_ffv;
    end
  end

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   vec_q[$];
  res_t res_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [1:0] md);
    if (cur_b) begin b_start = st; b_mode = md; end
    else begin a_start = st; a_mode = md; end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dut_in"}, o_in, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_pass"}, o_pass, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_ffv"}, o_ffv, 0);
    check({tag, "_ffvec"}, o_ffvec, 0);
  endtask

  // One full sweep: model the expected results, queue them, then compare as the DUT produces them.
  task automatic run_sweep(input logic use_b, input logic [1:0] m, input logic tie0, input logic hold);
    int   n, nvec, total, errmax, err, ffvec, exp_v;
    logic ffv, g, r;
    res_t res;
    cur_b = use_b;
    a_tie0 = tie0;
    n = use_b ? 3 : 2;
    nvec = 1 << n;
    total = nvec * DW;
    errmax = use_b ? 3 : 255;
    err = 0; ffv = 1'b0; ffvec = 0;
    for (int k = 0; k < nvec; k++) begin
      vec_q.push_back(k);
      g = use_b ? (k == nvec - 1) : (tie0 ? 1'b0 : (k == nvec - 1));
      case (m)
        2'd0:    r = (k == nvec - 1);
        2'd1:    r = (k != 0);
        2'd2:    r = 1'($countones(k) & 1);
        default: r = (k != nvec - 1);
      endcase
      if (g != r) begin
        if (err < errmax) err = err + 1;
        if (!ffv) begin ffv = 1'b1; ffvec = k; end
      end
    end
    res_q.push_back('{err, (err == 0), ffv, ffvec});

    @(negedge clk);
    drive(1'b1, m);
    @(posedge clk);
    for (int c = 1; c <= total + 2; c++) begin
      #1;
      if (c == 1) begin
        drive(hold, ~m);
        check("start_clears_err", o_err, 0);
        check("start_clears_pass", o_pass, 0);
        check("start_clears_ffv", o_ffv, 0);
      end
      if (c <= total) begin
        check("busy_run", o_busy, 1);
        check("done_early", o_done, 0);
        if (c % DW == 0) begin
          exp_v = (vec_q.size() > 0) ? vec_q.pop_front() : -1;
          check("dut_in_window", o_in, exp_v);
        end
      end else if (c == total + 1) begin
        check("done_pulse", o_done, 1);
        check("busy_done", o_busy, 1);
        check("dut_in_done", o_in, 0);
        check("res_q_depth", res_q.size(), 1);
        if (res_q.size() > 0) begin
          res = res_q.pop_front();
          check("err_count", o_err, res.err);
          check("pass", o_pass, res.pass);
          check("ffv", o_ffv, res.ffv);
          check("ffvec", o_ffvec, res.ffvec);
        end
      end else begin
        drive(1'b0, m);
        check("busy_fall", o_busy, 0);
        check("done_single", o_done, 0);
        check("err_held", o_err, err);
        check("pass_held", o_pass, (err == 0));
      end
      if (c < total + 2) @(posedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_mode = 2'd0; a_tie0 = 1'b0;
    b_start = 1'b0; b_mode = 2'd0;
    cur_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst_a");
    cur_b = 1'b1;
    #1;
    check_all_zero("rst_b");
    cur_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(1'b0, 2'd0, 1'b0, 1'b0);  // AND, correct gate
    run_sweep(1'b0, 2'd0, 1'b1, 1'b0);  // AND, output stuck at 0
    run_sweep(1'b0, 2'd2, 1'b0, 1'b0);  // XOR reference against an AND gate

    // Abort an AND sweep with reset in cycle 6, then rerun from scratch.
    cur_b = 1'b0; a_tie0 = 1'b0;
    @(negedge clk);
    drive(1'b1, 2'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 2'd0);
    repeat (5) @(posedge clk);
    #1;
    check("mid_dut_in", o_in, 1);
    check("mid_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #1;
    rst_n = 1'b1;
    vec_q.delete();
    res_q.delete();
    run_sweep(1'b0, 2'd0, 1'b0, 1'b0);

    run_sweep(1'b0, 2'd0, 1'b0, 1'b1);  // start held through the whole sweep and DONE
    run_sweep(1'b0, 2'd1, 1'b0, 1'b0);  // accepted one cycle later; OR vs AND gate
    run_sweep(1'b1, 2'd3, 1'b0, 1'b0);  // 3-input NAND vs AND gate, counter saturates

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Synthesizable, parametrised exhaustive stimulus-and-check engine for small combinational gates on the FPGA. On a start request it drives every input combination of an N-input gate in ascending binary order, holding each one for a fixed dwell time. At the end of each dwell it compares the gate's output against a built-in reference function: AND, OR, XOR or NAND. It sits next to the gate under test in the hello-world top level and reports pass/fail, a saturating error count and the first failing vector, so gate checks run on hardware rather than only in simulation.

## Interface
Parameters:
- N_IN, 2: gate input count; legal range 1..8.
- DWELL_CYCLES, 100: clocks each vector is held; must be ≥1.
- ERR_W, 8: width of the error counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- start  in  1  sweep request; sampled only in IDLE.
- mode  in  2  reference function: 0=AND, 1=OR, 2=XOR, 3=NAND; latched when start is accepted.
- dut_in  out  N_IN  stimulus to the gate under test.
- dut_out  in  1  gate output being checked.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse at the end of a sweep.
- pass  out  1  high when the last completed sweep had zero mismatches.
- err_count  out  ERR_W  mismatch count for the current or last sweep; saturates.
- first_fail_valid  out  1  high once any mismatch has been recorded.
- first_fail_vec  out  N_IN  vector of the first mismatch.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when start=1. This latches mode, sets vec=0 and dwell_cnt=0, and clears err_count, pass, first_fail_valid and first_fail_vec.
  - RUN: dwell_cnt increments every cycle.
  - When dwell_cnt==DWELL_CYCLES-1, dut_out is compared with ref(mode, vec).
    - On mismatch, err_count increments, saturating at 2^ERR_W-1.
    - On the first mismatch only, first_fail_vec←vec and first_fail_valid←1.
  - After the compare, dwell_cnt←0 and vec←vec+1.
  - If vec==2^N_IN-1 at that compare, the state goes to DONE instead.
  - DONE→IDLE unconditionally after one cycle.
- Reference function: AND = &vec, OR = |vec, XOR = ^vec, NAND = ~&vec.
- vec is an N_IN+1-bit counter internally, so the terminal test does not wrap.
- dut_in = vec[N_IN-1:0] in RUN, and 0 in IDLE and DONE.
- start is ignored in RUN and DONE; there is no queueing.
- mode changes during RUN have no effect.
- Results are held until the next accepted start.
- pass is set in DONE iff err_count==0.

## Timing
- Reset values: dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, state=IDLE.
- Assertion of rst_n clears every output immediately, including mid-sweep. A subsequent start runs a complete, fresh sweep.
- Cycle 0 is the edge at which start is sampled high in IDLE.
  - dut_in=vector k during cycles 1+k·DWELL_CYCLES through (k+1)·DWELL_CYCLES.
  - dut_out is sampled in the last cycle of each window.
  - done=1 and pass become valid in cycle 1+2^N_IN·DWELL_CYCLES.
  - busy falls one cycle after that.
- Gate path budget: dut_out must settle within DWELL_CYCLES-1 clocks of dut_in changing. DWELL_CYCLES=1 gives zero settling cycles and is only for registered-free direct checks.
- err_count and first_fail update on the edge following the sampling cycle.

## Structure
- Package gate_sweep_pkg holds:
  - mode_e enum (MODE_AND, MODE_OR, MODE_XOR, MODE_NAND).
  - state_e enum (IDLE, RUN, DONE).
  - Function gate_ref(mode_e, logic [7:0] vec, int n) returning the expected bit.
- No sub-module. The design is a single flat module with the FSM, the dwell counter, the vector counter and the result registers.

## Test plan
All scenarios use N_IN=2, DWELL_CYCLES=4 unless stated.
- AND mode, dut_out=&dut_in → dut_in steps 00,01,10,11 every 4 cycles; done pulses in cycle 17; pass=1, err_count=0, first_fail_valid=0.
- AND mode, dut_out tied 0 → err_count=1, first_fail_vec=2'b11, first_fail_valid=1, pass=0.
- XOR mode, dut_out=&dut_in → mismatches at 01, 10 and 11; err_count=3, first_fail_vec=2'b01, pass=0.
- rst_n pulsed low in cycle 6 of an AND sweep → all outputs 0 immediately and dut_in=0. A new start then gives a full sweep with done in cycle 17 relative to that start.
- start held high for the whole sweep and again in the DONE cycle → exactly one done pulse, no restart; a start one cycle later is accepted.
- N_IN=3, ERR_W=2, NAND mode, dut_out=&dut_in → all 8 vectors mismatch; err_count saturates at 3; first_fail_vec=3'b000; done in cycle 33.
